// File: rtl/dbus_pkg.sv
// dbus_pkg: shared types for the data-bus bridge (access size, bridge state, data word).
package dbus_pkg;

    typedef enum logic [1:0] {
        MSIZE_B = 2'b00,
        MSIZE_H = 2'b01,
        MSIZE_W = 2'b10
    } msize_t;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } dbus_state_t;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/dbus_lsu_align.sv
// dbus_lsu_align: combinational store-lane formatting and load extract/extend.
// Ports: addr_i (byte offset), size_i (msize_t), uns_i (zero-extend), wdata_i/rdata_i (raw data),
//        wstrb_o (byte enables), wdata_o (lane-replicated store data), rdata_o (extended load data).
module dbus_lsu_align
    import dbus_pkg::*;
(
    input  logic [1:0] addr_i,
    input  logic [1:0] size_i,
    input  logic       uns_i,
    input  word_t      wdata_i,
    input  word_t      rdata_i,
    output logic [3:0] wstrb_o,
    output word_t      wdata_o,
    output word_t      rdata_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b       = rdata_i[{addr_i, 3'b000} +: 8];
        h       = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        wstrb_o = size_i == MSIZE_B ? 4'b0001 << addr_i :
                  size_i == MSIZE_H ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_o = size_i == MSIZE_B ? {4{wdata_i[7:0]}} :
                  size_i == MSIZE_H ? {2{wdata_i[15:0]}} : wdata_i;
        rdata_o = size_i == MSIZE_B ? {{24{~uns_i & b[7]}}, b} :
                  size_i == MSIZE_H ? {{16{~uns_i & h[15]}}, h} : rdata_i;
    end

endmodule

// File: rtl/dbus_bridge.sv
// dbus_bridge: turns the M-stage load/store into one req/addr_ok + data_ok transaction on the data bus.
// Ports: clk, resetn (async active-low); M-stage side m_memread/m_memwrite/m_addr/m_size/m_unsigned/m_wdata
//        in, m_rdata/d_data_ok/m_adel/m_ades out; bus side data_req/data_wr/data_size/data_addr/data_wstrb/
//        data_wdata out, data_addr_ok/data_rdata/data_data_ok in.
// Optional: DBUS_ALIGN_CHECK_EN suppresses misaligned H/W accesses and flags m_adel/m_ades instead.
module dbus_bridge
    import dbus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  m_memread,
    input  logic                  m_memwrite,
    input  logic [ADDR_WIDTH-1:0] m_addr,
    input  logic [1:0]            m_size,
    input  logic                  m_unsigned,
    input  word_t                 m_wdata,
    output word_t                 m_rdata,
    output logic                  d_data_ok,
    output logic                  m_adel,
    output logic                  m_ades,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [3:0]            data_wstrb,
    output word_t                 data_wdata,
    input  logic                  data_addr_ok,
    input  word_t                 data_rdata,
    input  logic                  data_data_ok
);

    dbus_state_t state_q, state_d;
    logic        memop, mis, issue, done;
    logic [3:0]  wstrb;
    word_t       rdata_x;

    assign memop = m_memread | m_memwrite;
`ifdef DBUS_ALIGN_CHECK_EN
    assign mis = (m_size == MSIZE_H && m_addr[0]) || (m_size == MSIZE_W && m_addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    // resetn gates the combinational outputs so they read as reset values while reset is held
    assign issue = resetn & memop & ~mis;
    assign done  = resetn & (state_q == DATA) & data_data_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        data_req = 1'b0;
        if (state_q == IDLE) begin
            data_req = issue;
            if (issue && data_addr_ok) state_d = DATA;
        end else if (data_data_ok) begin
            state_d = IDLE;
        end
    end

    dbus_lsu_align u_align (
        .addr_i  (m_addr[1:0]),
        .size_i  (m_size),
        .uns_i   (m_unsigned),
        .wdata_i (m_wdata),
        .rdata_i (data_rdata),
        .wstrb_o (wstrb),
        .wdata_o (data_wdata),
        .rdata_o (rdata_x)
    );

    // the op stays in M while outstanding, so in DATA issue is 1 and completion alone decides
    assign d_data_ok  = ~issue | done;
    assign m_rdata    = (done & m_memread) ? rdata_x : 32'h0;
    assign m_adel     = resetn & m_memread & mis;
    assign m_ades     = resetn & m_memwrite & mis;
    assign data_wr    = m_memwrite;
    assign data_size  = m_size;
    assign data_addr  = m_addr;
    assign data_wstrb = m_memwrite ? wstrb : 4'b0000;

    // a response with nothing outstanding is a slave protocol error
    assert property (@(posedge clk) disable iff (!resetn) !(state_q == IDLE && data_data_ok));

endmodule

// File: tb/tb_dbus_bridge.sv
// tb_dbus_bridge: directed self-checking bench with a per-cycle behavioural model of the bridge.
module tb_dbus_bridge;

    logic        clk, resetn;
    logic        m_memread, m_memwrite, m_unsigned;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [1:0]  m_size;
    logic        d_data_ok, m_adel, m_ades;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;

    logic        s_rd, s_wr, s_uns;
    logic [31:0] s_addr, s_wd, s_rdat;
    logic [1:0]  s_size;
    logic        pend;
    int          checks = 0, passes = 0;

    dbus_bridge #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .m_memread(m_memread), .m_memwrite(m_memwrite), .m_addr(m_addr), .m_size(m_size),
        .m_unsigned(m_unsigned), .m_wdata(m_wdata), .m_rdata(m_rdata), .d_data_ok(d_data_ok),
        .m_adel(m_adel), .m_ades(m_ades),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_rdata(data_rdata), .data_data_ok(data_data_ok)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic misal();
`ifdef DBUS_ALIGN_CHECK_EN
        return (m_memread || m_memwrite) && (m_addr % (32'd1 << m_size)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_req();
        return resetn && (m_memread || m_memwrite) && !pend && !misal();
    endfunction

    function automatic int lane_base();
        int nb;
        nb = 1 << m_size;
        return int'(m_addr[1:0]) / nb * nb;
    endfunction

    function automatic logic [3:0] exp_strb();
        logic [3:0] s;
        int nb, base;
        nb = 1 << m_size;
        base = lane_base();
        for (int b = 0; b < 4; b++) s[b] = m_memwrite && b >= base && b < base + nb;
        return s;
    endfunction

    function automatic logic [31:0] exp_wdata();
        logic [31:0] w;
        int nb;
        nb = 1 << m_size;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = m_wdata[8*(b % nb) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ld_val();
        logic [31:0] v, mask;
        int nb;
        nb = 1 << m_size;
        if (nb >= 4) return data_rdata;
        mask = (32'd1 << (8 * nb)) - 1;
        v = (data_rdata >> (8 * lane_base())) & mask;
        if (!m_unsigned && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    always @(posedge clk or negedge resetn)
        if (!resetn) pend <= 1'b0;
        else if (pend) begin
            if (data_data_ok) pend <= 1'b0;
        end else if (exp_req() && data_addr_ok) pend <= 1'b1;

    always @(negedge clk) begin
        logic er, eok, fin;
        er  = exp_req();
        fin = resetn && pend && data_data_ok;
        eok = !resetn || !(m_memread || m_memwrite) || misal() || fin;
        chk("req", data_req, er);
        chk("d_data_ok", d_data_ok, eok);
        chk("m_rdata", m_rdata, (fin && m_memread) ? ld_val() : 32'h0);
        chk("m_adel", m_adel, resetn && m_memread && misal());
        chk("m_ades", m_ades, resetn && m_memwrite && misal());
        if (er) begin
            chk("data_wr", data_wr, m_memwrite);
            chk("data_addr", data_addr, m_addr);
            chk("data_size", data_size, m_size);
            chk("data_wstrb", data_wstrb, exp_strb());
            if (m_memwrite) chk("data_wdata", data_wdata, exp_wdata());
        end
    end

    task automatic op(input logic rd, input logic wr, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wd, input logic [31:0] rdat);
        s_rd = rd; s_wr = wr; s_addr = addr; s_size = size; s_uns = uns; s_wd = wd; s_rdat = rdat;
    endtask

    task automatic drive(input logic aok, input logic dok);
        @(posedge clk);
        #1;
        m_memread = s_rd; m_memwrite = s_wr; m_addr = s_addr; m_size = s_size;
        m_unsigned = s_uns; m_wdata = s_wd; data_rdata = s_rdat;
        data_addr_ok = aok; data_data_ok = dok;
        @(negedge clk);
    endtask

    initial begin
        resetn = 0;
        m_memread = 0; m_memwrite = 0; m_addr = 0; m_size = 0; m_unsigned = 0; m_wdata = 0;
        data_rdata = 0; data_addr_ok = 0; data_data_ok = 0;
        op(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_req", data_req, 0);
        chk("rst_ok", d_data_ok, 1);
        chk("rst_adel", m_adel, 0);
        @(posedge clk);
        #1 resetn = 1;
        drive(0, 0);
        chk("idle_ok", d_data_ok, 1);

        op(1, 0, 32'h100, 2'b10, 0, 0, 32'hDEADBEEF);
        drive(1, 0); chk("lw_c0_req", data_req, 1); chk("lw_c0_ok", d_data_ok, 0);
        drive(0, 0); chk("lw_c1_req", data_req, 0); chk("lw_c1_ok", d_data_ok, 0);
        drive(0, 1); chk("lw_c2_ok", d_data_ok, 1); chk("lw_rdata", m_rdata, 32'hDEADBEEF);

        op(1, 0, 32'h103, 2'b00, 0, 0, 32'h80FFFFFF);
        drive(1, 0); drive(0, 1); chk("lb_rdata", m_rdata, 32'hFFFFFF80);
        op(1, 0, 32'h103, 2'b00, 1, 0, 32'h80FFFFFF);
        drive(1, 0); drive(0, 1); chk("lbu_rdata", m_rdata, 32'h00000080);

        op(0, 1, 32'h102, 2'b01, 0, 32'h1234ABCD, 0);
        drive(1, 0); chk("sh_wstrb", data_wstrb, 4'b1100); chk("sh_wdata", data_wdata, 32'hABCDABCD);
        chk("sh_wr", data_wr, 1);
        drive(0, 1); chk("sh_ok", d_data_ok, 1); chk("sh_rdata", m_rdata, 0);

        op(0, 1, 32'h1, 2'b00, 0, 32'h000000A5, 0);
        drive(1, 0); chk("sb_wstrb", data_wstrb, 4'b0010); chk("sb_wdata", data_wdata, 32'hA5A5A5A5);
        drive(0, 1);
        op(0, 1, 32'h8, 2'b10, 0, 32'h11223344, 0);
        drive(1, 0); chk("sw_wstrb", data_wstrb, 4'b1111); chk("sw_wdata", data_wdata, 32'h11223344);
        drive(0, 1);

        op(1, 0, 32'h204, 2'b10, 0, 0, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0);
            chk("wait_req", data_req, 1); chk("wait_addr", data_addr, 32'h204);
            chk("wait_size", data_size, 2'b10); chk("wait_ok", d_data_ok, 0);
        end
        drive(1, 0); chk("acc_req", data_req, 1);
        drive(0, 0); chk("acc_ok", d_data_ok, 0); chk("acc_req_low", data_req, 0);
        drive(0, 1); chk("wait_rdata", m_rdata, 32'hCAFEF00D);

        op(1, 0, 32'h10, 2'b01, 1, 0, 32'h1234F00D);
        drive(1, 0); drive(0, 1); chk("b2b_first_done_req", data_req, 0);
        chk("lhu_rdata", m_rdata, 32'h0000F00D);
        op(1, 0, 32'h12, 2'b01, 0, 0, 32'h80010000);
        drive(1, 0); chk("b2b_second_req", data_req, 1); chk("b2b_second_ok", d_data_ok, 0);
        drive(0, 1); chk("lh_rdata", m_rdata, 32'hFFFF8001);

        op(1, 0, 32'h300, 2'b10, 0, 0, 0);
        drive(1, 0); drive(0, 0); chk("pre_rst_ok", d_data_ok, 0);
        #2 resetn = 0;
        #1;
        chk("arst_req", data_req, 0); chk("arst_ok", d_data_ok, 1); chk("arst_rdata", m_rdata, 0);
        m_memread = 0;
        op(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 resetn = 1;
        drive(0, 0); chk("post_rst_req", data_req, 0);

`ifdef DBUS_ALIGN_CHECK_EN
        op(1, 0, 32'h101, 2'b10, 0, 0, 32'h55555555);
        drive(1, 0);
        chk("mis_adel", m_adel, 1); chk("mis_req", data_req, 0); chk("mis_ok", d_data_ok, 1);
        chk("mis_rdata", m_rdata, 0);
        op(0, 1, 32'h101, 2'b01, 0, 32'h1234, 0);
        drive(1, 0); chk("mis_ades", m_ades, 1); chk("mis_st_req", data_req, 0);
`else
        op(1, 0, 32'h101, 2'b10, 0, 0, 32'h55555555);
        drive(1, 0); chk("mis_req", data_req, 1); chk("mis_adel", m_adel, 0);
        drive(0, 1); chk("mis_rdata", m_rdata, 32'h55555555);
`endif
        op(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0); chk("end_ok", d_data_ok, 1);
        drive(0, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
